// File: rtl/bus_reg_slice.sv
// Registered request/response slice between the arbitrated master port and the slave bus.
// Every output is a flop; a stalled slave is aborted with ERR_DATA after TIMEOUT cycles.
module bus_reg_slice #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [31:0] m_addr,
    output logic [31:0] m_rdata,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    input  logic [31:0] s_rdata,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        err,
    input  logic        err_clr
);

    // A zero TIMEOUT still needs a 1-bit counter so the declarations stay legal.
    localparam int               CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic             TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              m_ready_reg, m_ready_next;
    logic [31:0]       m_rdata_reg, m_rdata_next;
    logic              s_valid_reg, s_valid_next;
    logic [31:0]       s_addr_reg, s_addr_next;
    logic [31:0]       s_wdata_reg, s_wdata_next;
    logic [3:0]        s_wstrb_reg, s_wstrb_next;
    logic              err_reg, err_next;
    logic              abort;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            m_ready_reg <= 1'b0;
            m_rdata_reg <= '0;
            s_valid_reg <= 1'b0;
            s_addr_reg  <= '0;
            s_wdata_reg <= '0;
            s_wstrb_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            m_ready_reg <= m_ready_next;
            m_rdata_reg <= m_rdata_next;
            s_valid_reg <= s_valid_next;
            s_addr_reg  <= s_addr_next;
            s_wdata_reg <= s_wdata_next;
            s_wstrb_reg <= s_wstrb_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        m_ready_next = 1'b0;
        m_rdata_next = m_rdata_reg;
        s_valid_next = s_valid_reg;
        s_addr_next  = s_addr_reg;
        s_wdata_next = s_wdata_reg;
        s_wstrb_next = s_wstrb_reg;
        abort        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (m_valid) begin
                    s_addr_next  = m_addr;
                    s_wdata_next = m_wdata;
                    s_wstrb_next = m_wstrb;
                    s_valid_next = 1'b1;
                    cnt_next     = '0;
                    state_next   = ST_REQ;
                end
            end
            ST_REQ: begin
                // A completion in the last allowed cycle beats the abort.
                if (s_ready) begin
                    m_rdata_next = s_rdata;
                    s_valid_next = 1'b0;
                    m_ready_next = 1'b1;
                    state_next   = ST_RESP;
                end else begin
                    if (cnt_reg != '1) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                    if (TIMEOUT_EN && (cnt_reg == CNT_LAST)) begin
                        abort        = 1'b1;
                        m_rdata_next = ERR_DATA;
                        s_valid_next = 1'b0;
                        m_ready_next = 1'b1;
                        state_next   = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next   = ST_IDLE;
                s_valid_next = 1'b0;
            end
        endcase

        // Setting on abort takes priority over a simultaneous clear.
        err_next = abort | (err_reg & ~err_clr);
    end

    assign m_ready = m_ready_reg;
    assign m_rdata = m_rdata_reg;
    assign s_valid = s_valid_reg;
    assign s_addr  = s_addr_reg;
    assign s_wdata = s_wdata_reg;
    assign s_wstrb = s_wstrb_reg;
    assign err     = err_reg;

endmodule
